// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if
// One valid/ready stream carrying a logic-unit result: data word, Z/N/P
// flags and the opcode that produced it.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// The master holds valid and payload stable until that edge. The slave
// may drive ready independently of valid.
//
//   valid  master->slave  payload present
//   ready  slave->master  slave accepts this cycle
//   data   master->slave  result word (Width bits)
//   z/n/p  master->slave  zero / negative / positive flags
//   op     master->slave  opcode F
interface alu_result_fifo_if #(
  parameter int Width = 16
);
  logic             valid;
  logic             ready;
  logic [Width-1:0] data;
  logic             z;
  logic             n;
  logic             p;
  logic [2:0]       op;

  modport master (
    output valid, data, z, n, p, op,
    input  ready
  );

  modport slave (
    input  valid, data, z, n, p, op,
    output ready
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Registered output stage behind the combinational logic unit. Results
// with a supported opcode (op[2]=0) are queued with their flags; results
// with op[2]=1 are accepted but discarded and counted. Popped entries
// feed sticky Z/N/P summaries.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_if        slave stream from the logic unit (ready = count != Depth)
//   out_if       master stream to the consumer   (valid = count != 0)
//   count        current occupancy
//   sticky_z/n/p OR of flags of all entries popped since the last clear
//   sticky_clr   synchronous clear of the sticky flags
//   bad_op_cnt   discarded unsupported-opcode results, saturating at 255
module alu_result_fifo #(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_fifo_if.slave       in_if,
  alu_result_fifo_if.master      out_if,
  output logic [$clog2(Depth):0] count,
  output logic                   sticky_z,
  output logic                   sticky_n,
  output logic                   sticky_p,
  input  logic                   sticky_clr,
  output logic [7:0]             bad_op_cnt
);

  localparam int              AW   = $clog2(Depth);
  localparam logic [AW:0]     FULL = (AW+1)'(Depth);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [Width-1:0] mem_data [Depth];
  logic [5:0]       mem_tag  [Depth];  // {z, n, p, op}

  logic accept;
  logic push;
  logic discard;
  logic pop;

  // Both ready and valid come from the registered count only, so there is
  // no combinational path from in_if.valid or out_if.ready to any output.
  assign in_if.ready  = (count != FULL);
  assign out_if.valid = (count != '0);

  assign accept  = in_if.valid && in_if.ready;
  assign push    = accept && !in_if.op[2];
  assign discard = accept &&  in_if.op[2];
  assign pop     = out_if.valid && out_if.ready;

  // Head entry is read straight from storage; stale when empty.
  assign out_if.data = mem_data[rd_ptr];
  assign {out_if.z, out_if.n, out_if.p, out_if.op} = mem_tag[rd_ptr];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_if.data;
      mem_tag[wr_ptr]  <= {in_if.z, in_if.n, in_if.p, in_if.op};
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pop in the same cycle as a clear keeps the popped entry's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_z <= 1'b0;
      sticky_n <= 1'b0;
      sticky_p <= 1'b0;
    end else if (pop) begin
      sticky_z <= (sticky_clr ? 1'b0 : sticky_z) | out_if.z;
      sticky_n <= (sticky_clr ? 1'b0 : sticky_n) | out_if.n;
      sticky_p <= (sticky_clr ? 1'b0 : sticky_p) | out_if.p;
    end else if (sticky_clr) begin
      sticky_z <= 1'b0;
      sticky_n <= 1'b0;
      sticky_p <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_op_cnt <= '0;
    end else if (discard && (bad_op_cnt != 8'hFF)) begin
      bad_op_cnt <= bad_op_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int Width = 16;
  localparam int Depth = 4;
  localparam int EW    = Width + 6;  // {data, z, n, p, op}

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  logic       sticky_z;
  logic       sticky_n;
  logic       sticky_p;
  logic       sticky_clr;
  logic [7:0] bad_op_cnt;

  alu_result_fifo_if #(.Width(Width)) in_bus ();
  alu_result_fifo_if #(.Width(Width)) out_bus ();

  alu_result_fifo #(.Width(Width), .Depth(Depth)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_bus),
    .out_if     (out_bus),
    .count      (count),
    .sticky_z   (sticky_z),
    .sticky_n   (sticky_n),
    .sticky_p   (sticky_p),
    .sticky_clr (sticky_clr),
    .bad_op_cnt (bad_op_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Plain queue of accepted supported-opcode results plus counters.
  logic [EW-1:0] exp_q[$];
  logic          m_sz, m_sn, m_sp;
  int            m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sz  = 1'b0;
      m_sn  = 1'b0;
      m_sp  = 1'b0;
      m_bad = 0;
    end else begin
      logic          acc;
      logic          pp;
      logic [EW-1:0] head;
      acc = in_bus.valid && (exp_q.size() != Depth);
      pp  = (exp_q.size() != 0) && out_bus.ready;
      if (pp) begin
        head = exp_q.pop_front();
        if (sticky_clr) begin
          m_sz = 1'b0; m_sn = 1'b0; m_sp = 1'b0;
        end
        m_sz = m_sz | head[5];
        m_sn = m_sn | head[4];
        m_sp = m_sp | head[3];
      end else if (sticky_clr) begin
        m_sz = 1'b0; m_sn = 1'b0; m_sp = 1'b0;
      end
      if (acc) begin
        if (in_bus.op[2]) begin
          if (m_bad < 255) m_bad++;
        end else begin
          exp_q.push_back({in_bus.data, in_bus.z, in_bus.n, in_bus.p, in_bus.op});
        end
      end
    end
  end

  // ---------------- compare process (every negedge) ----------------
  always @(negedge clk) begin
    check("out_valid", 32'(out_bus.valid), 32'(exp_q.size() != 0));
    check("in_ready",  32'(in_bus.ready),  32'(exp_q.size() != Depth));
    check("count",     32'(count),         32'(exp_q.size()));
    check("sticky_z",  32'(sticky_z),      32'(m_sz));
    check("sticky_n",  32'(sticky_n),      32'(m_sn));
    check("sticky_p",  32'(sticky_p),      32'(m_sp));
    check("bad_op_cnt", 32'(bad_op_cnt),   32'(m_bad));
    if (exp_q.size() != 0) begin
      check("head", 32'({out_bus.data, out_bus.z, out_bus.n, out_bus.p, out_bus.op}),
            32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold one beat on the input until it is accepted (bounded).
  task automatic send(input logic [15:0] d, input logic z, input logic n,
                      input logic p, input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    in_bus.valid = 1'b1;
    in_bus.data  = d;
    in_bus.z = z; in_bus.n = n; in_bus.p = p;
    in_bus.op = op;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ok = in_bus.ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 32'(in_bus.ready), 32'd1);
    in_bus.valid = 1'b0;
  endtask

  // Wait (bounded) for a head entry, check it, let the edge pop it.
  task automatic expect_pop(input logic [15:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_bus.valid) begin
        found = 1'b1;
        break;
      end
    end
    if (found) check("pop_data", 32'(out_bus.data), 32'(d));
    else       check("pop_timeout", 32'(out_bus.valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    sticky_clr    = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    in_bus.z      = 1'b0;
    in_bus.n      = 1'b0;
    in_bus.p      = 1'b0;
    in_bus.op     = '0;
    out_bus.ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_bus.valid), 32'd0);
    check("rst_in_ready",  32'(in_bus.ready),  32'd1);
    check("rst_count",     32'(count),         32'd0);
    check("rst_bad",       32'(bad_op_cnt),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // First push shows on the outputs one cycle later.
    send(16'h00F0, 1'b0, 1'b0, 1'b1, 3'b000);
    check("t1_valid", 32'(out_bus.valid), 32'd1);
    check("t1_data",  32'(out_bus.data),  32'h00F0);
    check("t1_p",     32'(out_bus.p),     32'd1);
    check("t1_count", 32'(count),         32'd1);
    out_bus.ready = 1'b1;
    idle(1);
    out_bus.ready = 1'b0;

    // Fill, then a fifth held while full, then drain in order.
    for (int i = 1; i <= 4; i++) send(16'(i), 1'b0, 1'b0, 1'b1, 3'b001);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_bus.ready), 32'd0);
    fork
      send(16'h0005, 1'b0, 1'b0, 1'b1, 3'b010);
      begin
        idle(2);
        out_bus.ready = 1'b1;
        for (int k = 1; k <= 5; k++) expect_pop(16'(k));
        out_bus.ready = 1'b0;
      end
    join
    check("drain_count", 32'(count), 32'd0);

    // Streaming at count=1 across several pointer wraps.
    send(16'h0100, 1'b0, 1'b0, 1'b1, 3'b011);
    in_bus.valid  = 1'b1;
    out_bus.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_bus.data = 16'h0200 + 16'(i);
      in_bus.z = 1'b0; in_bus.n = 1'b0; in_bus.p = 1'b1;
      in_bus.op = 3'(i % 4);
      idle(1);
    end
    in_bus.valid  = 1'b0;
    out_bus.ready = 1'b0;
    check("stream_count", 32'(count), 32'd1);
    check("stream_last",  32'(out_bus.data), 32'h0209);
    out_bus.ready = 1'b1;
    idle(1);
    out_bus.ready = 1'b0;

    // Unsupported opcodes are swallowed and counted, saturating.
    send(16'hBAD1, 1'b0, 1'b0, 1'b1, 3'b100);
    send(16'hBAD2, 1'b0, 1'b1, 1'b0, 3'b111);
    check("bad_two",   32'(bad_op_cnt),    32'd2);
    check("bad_empty", 32'(out_bus.valid), 32'd0);
    in_bus.valid = 1'b1;
    in_bus.op    = 3'b100;
    idle(298);
    in_bus.valid = 1'b0;
    check("bad_sat", 32'(bad_op_cnt), 32'd255);

    // Sticky flags.
    sticky_clr = 1'b1;
    idle(1);
    sticky_clr = 1'b0;
    check("clr_z", 32'(sticky_z), 32'd0);
    check("clr_n", 32'(sticky_n), 32'd0);
    check("clr_p", 32'(sticky_p), 32'd0);
    send(16'h8000, 1'b0, 1'b1, 1'b0, 3'b001);
    send(16'h0000, 1'b1, 1'b0, 1'b0, 3'b010);
    out_bus.ready = 1'b1;
    idle(2);
    out_bus.ready = 1'b0;
    check("stk_n", 32'(sticky_n), 32'd1);
    check("stk_z", 32'(sticky_z), 32'd1);
    check("stk_p", 32'(sticky_p), 32'd0);
    send(16'h0000, 1'b1, 1'b0, 1'b0, 3'b011);
    out_bus.ready = 1'b1;
    sticky_clr    = 1'b1;
    idle(1);
    out_bus.ready = 1'b0;
    sticky_clr    = 1'b0;
    check("clrpop_z", 32'(sticky_z), 32'd1);
    check("clrpop_n", 32'(sticky_n), 32'd0);
    check("clrpop_count", 32'(count), 32'd0);

    // Asynchronous reset with entries in flight.
    send(16'hA001, 1'b0, 1'b0, 1'b1, 3'b000);
    send(16'hA002, 1'b0, 1'b0, 1'b1, 3'b000);
    send(16'hA003, 1'b0, 1'b0, 1'b1, 3'b000);
    check("pre_rst_count", 32'(count), 32'd3);
    in_bus.valid = 1'b1;
    in_bus.data  = 16'hDEAD;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count),         32'd0);
    check("arst_valid", 32'(out_bus.valid), 32'd0);
    check("arst_ready", 32'(in_bus.ready),  32'd1);
    in_bus.valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(16'h5A5A, 1'b0, 1'b0, 1'b1, 3'b000);
    check("post_rst_data",  32'(out_bus.data), 32'h5A5A);
    check("post_rst_count", 32'(count),        32'd1);
    out_bus.ready = 1'b1;
    idle(1);
    out_bus.ready = 1'b0;
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
